// File: rtl/tdc_pkg.sv
// Shared types and width helpers for the TDC capture/accumulate back-end.
package tdc_pkg;

    // Per-sample encode selection; RSVD decodes like POP.
    typedef enum logic [1:0] {
        POP     = 2'd0,
        POP_INV = 2'd1,
        THERM   = 2'd2,
        RSVD    = 2'd3
    } tdc_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        ACCUM = 2'd2,
        HOLD  = 2'd3
    } tdc_acc_state_e;

    // One encoded sample must represent 0..n inclusive.
    function automatic int hw_width(input int n);
        return $clog2(n) + 1;
    endfunction

    // n * 2^acc_log2_max fits once acc_log2_max extra bits are added.
    function automatic int sum_width(input int n, input int acc_log2_max);
        return hw_width(n) + acc_log2_max;
    endfunction

endpackage

// File: rtl/tdc_encode.sv
// Encodes one synchronised capture word and registers the result with en gating.
module tdc_encode
    import tdc_pkg::*;
#(
    parameter  int N    = 64,
    localparam int HW_W = hw_width(N)
) (
    input  logic            clk_capture,
    input  logic            rst_n,
    input  logic            en_i,
    input  logic [N-1:0]    data_i,
    input  logic [1:0]      mode_i,
    output logic [HW_W-1:0] sample_o,
    output logic            oor_o
);

    logic [HW_W-1:0] pop, therm, enc;
    logic            run;
    logic [HW_W-1:0] sample_q;
    logic            oor_q;

    // Mode mux: ones count, zeros count, or length of the ones run from bit 0.
    always_comb begin
        pop   = '0;
        therm = '0;
        run   = 1'b1;
        for (int i = 0; i < N; i++) begin
            pop   = pop + HW_W'(data_i[i]);
            run   = run & data_i[i];
            therm = therm + HW_W'(run);
        end
        case (tdc_mode_e'(mode_i))
            POP_INV: enc = HW_W'(N) - pop;
            THERM:   enc = therm;
            default: enc = pop;
        endcase
    end

    // Output register advances with the sync chain so latency counts en-high cycles.
    always_ff @(posedge clk_capture or negedge rst_n) begin
        if (!rst_n) begin
            sample_q <= '0;
            oor_q    <= 1'b0;
        end else if (en_i) begin
            sample_q <= enc;
            oor_q    <= (enc == '0) || (enc == HW_W'(N));
        end
    end

    assign sample_o = sample_q;
    assign oor_o    = oor_q;

endmodule

// File: rtl/tdc_capture_accum.sv
// TDC back-end: synchroniser chain, per-sample encode, burst accumulation of
// sum/min/max/out-of-range, and a valid/ready result port.
module tdc_capture_accum
    import tdc_pkg::*;
#(
    parameter  int N            = 64,
    parameter  int N_SYNC       = 2,
    parameter  int ACC_LOG2_MAX = 4,
    localparam int HW_W         = hw_width(N),
    localparam int SUM_W        = sum_width(N, ACC_LOG2_MAX),
    localparam int SEL_W        = $clog2(ACC_LOG2_MAX + 1),
    localparam int OOR_W        = ACC_LOG2_MAX + 1
) (
    input  logic             clk_capture,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N-1:0]     dl_in,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [SEL_W-1:0] acc_sel,
    output logic             busy,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic [SUM_W-1:0] meas_sum,
    output logic [HW_W-1:0]  meas_min,
    output logic [HW_W-1:0]  meas_max,
    output logic [OOR_W-1:0] meas_oor
);

    localparam int FL_W = $clog2(N_SYNC + 2);

    logic [N_SYNC-1:0][N-1:0] sync_q;
    logic [HW_W-1:0]          sample;
    logic                     sample_oor;

    tdc_acc_state_e   state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [FL_W-1:0]  flush_q, flush_d;
    logic [OOR_W-1:0] samp_q, samp_d;
    logic [SUM_W-1:0] acc_sum_q, acc_sum_d, sum_n;
    logic [HW_W-1:0]  acc_min_q, acc_min_d, min_n;
    logic [HW_W-1:0]  acc_max_q, acc_max_d, max_n;
    logic [OOR_W-1:0] acc_oor_q, acc_oor_d, oor_n;
    logic [SUM_W-1:0] meas_sum_q, meas_sum_d;
    logic [HW_W-1:0]  meas_min_q, meas_min_d;
    logic [HW_W-1:0]  meas_max_q, meas_max_d;
    logic [OOR_W-1:0] meas_oor_q, meas_oor_d;
    logic [SEL_W-1:0] k_sel;

    // Synchroniser chain; frozen while en is low.
    always_ff @(posedge clk_capture or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else if (en) begin
            sync_q[0] <= dl_in;
            for (int i = 1; i < N_SYNC; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    tdc_encode #(.N(N)) u_enc (
        .clk_capture (clk_capture),
        .rst_n       (rst_n),
        .en_i        (en),
        .data_i      (sync_q[N_SYNC-1]),
        .mode_i      (mode_q),
        .sample_o    (sample),
        .oor_o       (sample_oor)
    );

    assign k_sel = (acc_sel > SEL_W'(ACC_LOG2_MAX)) ? SEL_W'(ACC_LOG2_MAX) : acc_sel;

    // Running statistics including the current sample. oor cannot pass 2^k
    // because at most 2^k samples are folded in per burst.
    always_comb begin
        sum_n = acc_sum_q + SUM_W'(sample);
        min_n = (sample < acc_min_q) ? sample : acc_min_q;
        max_n = (sample > acc_max_q) ? sample : acc_max_q;
        oor_n = acc_oor_q + OOR_W'(sample_oor);
    end

    // Burst FSM: latch config on accepted start, flush stale pipeline, accumulate, hold.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        flush_d    = flush_q;
        samp_d     = samp_q;
        acc_sum_d  = acc_sum_q;
        acc_min_d  = acc_min_q;
        acc_max_d  = acc_max_q;
        acc_oor_d  = acc_oor_q;
        meas_sum_d = meas_sum_q;
        meas_min_d = meas_min_q;
        meas_max_d = meas_max_q;
        meas_oor_d = meas_oor_q;
        case (state_q)
            IDLE, HOLD: begin
                if (state_q == IDLE || meas_ready) begin
                    if (start) begin
                        state_d   = FLUSH;
                        mode_d    = mode;
                        flush_d   = FL_W'(N_SYNC + 1);
                        samp_d    = OOR_W'(1) << k_sel;
                        acc_sum_d = '0;
                        acc_min_d = '1;
                        acc_max_d = '0;
                        acc_oor_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            FLUSH: begin
                if (en) begin
                    if (flush_q == '0) state_d = ACCUM;
                    else               flush_d = flush_q - 1'b1;
                end
            end
            ACCUM: begin
                if (en) begin
                    acc_sum_d = sum_n;
                    acc_min_d = min_n;
                    acc_max_d = max_n;
                    acc_oor_d = oor_n;
                    samp_d    = samp_q - 1'b1;
                    if (samp_q == OOR_W'(1)) begin
                        state_d    = HOLD;
                        meas_sum_d = sum_n;
                        meas_min_d = min_n;
                        meas_max_d = max_n;
                        meas_oor_d = oor_n;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, accumulator and result registers.
    always_ff @(posedge clk_capture or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mode_q     <= '0;
            flush_q    <= '0;
            samp_q     <= '0;
            acc_sum_q  <= '0;
            acc_min_q  <= '0;
            acc_max_q  <= '0;
            acc_oor_q  <= '0;
            meas_sum_q <= '0;
            meas_min_q <= '0;
            meas_max_q <= '0;
            meas_oor_q <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            flush_q    <= flush_d;
            samp_q     <= samp_d;
            acc_sum_q  <= acc_sum_d;
            acc_min_q  <= acc_min_d;
            acc_max_q  <= acc_max_d;
            acc_oor_q  <= acc_oor_d;
            meas_sum_q <= meas_sum_d;
            meas_min_q <= meas_min_d;
            meas_max_q <= meas_max_d;
            meas_oor_q <= meas_oor_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign meas_valid = (state_q == HOLD);
    assign meas_sum   = meas_sum_q;
    assign meas_min   = meas_min_q;
    assign meas_max   = meas_max_q;
    assign meas_oor   = meas_oor_q;

endmodule

// File: tb/tb_tdc_capture_accum.sv
// Directed bench for tdc_capture_accum with a scoreboard of expected bursts.
module tb_tdc_capture_accum;

    localparam int N = 64, N_SYNC = 2, AMAX = 4;
    localparam int HW_W = $clog2(N) + 1, SUM_W = HW_W + AMAX;
    localparam int SEL_W = $clog2(AMAX + 1), OOR_W = AMAX + 1;

    logic             clk = 1'b0;
    logic             rst_n, en, start, meas_ready;
    logic [N-1:0]     dl_in;
    logic [1:0]       mode;
    logic [SEL_W-1:0] acc_sel;
    logic             busy, meas_valid;
    logic [SUM_W-1:0] meas_sum;
    logic [HW_W-1:0]  meas_min, meas_max;
    logic [OOR_W-1:0] meas_oor;

    typedef struct {
        longint sum, mn, mx, oor, lat;
    } exp_t;
    exp_t sb[$];
    int checks = 0, failures = 0;

    tdc_capture_accum #(.N(N), .N_SYNC(N_SYNC), .ACC_LOG2_MAX(AMAX)) dut (
        .clk_capture (clk), .rst_n (rst_n), .en (en), .dl_in (dl_in),
        .start (start), .mode (mode), .acc_sel (acc_sel), .busy (busy),
        .meas_valid (meas_valid), .meas_ready (meas_ready), .meas_sum (meas_sum),
        .meas_min (meas_min), .meas_max (meas_max), .meas_oor (meas_oor)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int enc_model(input logic [63:0] w, input int m);
        int n;
        case (m)
            1: return N - $countones(w);
            2: begin
                n = 0;
                while (n < N && w[n]) n++;
                return n;
            end
            default: return $countones(w);
        endcase
    endfunction

    function automatic exp_t model(input logic [63:0] w, input int m, input int k);
        exp_t e;
        int kk = (k > AMAX) ? AMAX : k;
        int v  = enc_model(w, m);
        e.sum = v << kk;
        e.mn  = v;
        e.mx  = v;
        e.oor = (v == 0 || v == N) ? (1 << kk) : 0;
        e.lat = N_SYNC + 2 + (1 << kk);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge; scramble config afterwards to show it is latched.
    task automatic start_burst(input logic [63:0] w, input int m, input int k, input bit push);
        dl_in = w; mode = 2'(m); acc_sel = SEL_W'(k); start = 1'b1;
        if (push) sb.push_back(model(w, m, k));
        tick();
        start = 1'b0; mode = ~mode; acc_sel = SEL_W'(1);
    endtask

    task automatic wait_result(input string tag, output exp_t e);
        int cnt = 0;
        while (!meas_valid && cnt < 200) begin
            tick();
            cnt++;
        end
        e = sb.pop_front();
        check({tag, "_valid"}, 64'(meas_valid), 64'd1);
        check({tag, "_lat"}, 64'(cnt), 64'(e.lat));
        check({tag, "_sum"}, 64'(meas_sum), 64'(e.sum));
        check({tag, "_min"}, 64'(meas_min), 64'(e.mn));
        check({tag, "_max"}, 64'(meas_max), 64'(e.mx));
        check({tag, "_oor"}, 64'(meas_oor), 64'(e.oor));
    endtask

    task automatic handshake(input string tag);
        meas_ready = 1'b1;
        tick();
        meas_ready = 1'b0;
        check({tag, "_valid_drop"}, 64'(meas_valid), 64'd0);
        check({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    task automatic burst(input string tag, input logic [63:0] w, input int m, input int k);
        exp_t e;
        start_burst(w, m, k, 1'b1);
        wait_result(tag, e);
        handshake(tag);
    endtask

    initial begin
        exp_t e;
        int cnt, rises;
        rst_n = 1'b0; en = 1'b1; start = 1'b0; meas_ready = 1'b0;
        dl_in = '0; mode = '0; acc_sel = '0;
        repeat (3) tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(meas_valid), 64'd0);
        check("rst_sum", 64'(meas_sum), 64'd0);
        check("rst_minmax", 64'({meas_min, meas_max, meas_oor}), 64'd0);
        rst_n = 1'b1;
        tick();

        // Basic, encode modes, out-of-range, acc_sel clamp.
        burst("basic", 64'h0000_0000_FFFF_FFFF, 0, 2);
        burst("therm", 64'h0000_0000_0000_00F7, 2, 0);
        burst("pop",   64'h0000_0000_0000_00F7, 0, 0);
        burst("inv",   64'h0000_0000_0000_00F7, 1, 0);
        burst("ones",  '1, 0, 2);
        burst("zeros", '0, 0, 2);
        burst("rsvd",  64'h0000_0000_0000_0FFF, 3, 1);
        burst("clamp", 64'h0000_0000_0000_00FF, 0, 7);

        // Backpressure: result stays put for 10 cycles, extra starts ignored.
        start_burst(64'h0000_0000_0000_03FF, 0, 1, 1'b1);
        wait_result("bp", e);
        dl_in = '1;
        for (int i = 0; i < 10; i++) begin
            start = (i == 2 || i == 5);
            tick();
            start = 1'b0;
            check("bp_hold_valid", 64'(meas_valid), 64'd1);
            check("bp_hold_sum", 64'(meas_sum), 64'(e.sum));
        end
        handshake("bp");

        // Transfer and restart in the same cycle.
        start_burst(64'h0000_0000_0000_000F, 0, 2, 1'b1);
        wait_result("b2b_a", e);
        dl_in = 64'h0000_0000_00FF_FFFF; mode = 2'd0; acc_sel = SEL_W'(2);
        start = 1'b1; meas_ready = 1'b1;
        sb.push_back(model(dl_in, 0, 2));
        tick();
        start = 1'b0; meas_ready = 1'b0;
        check("b2b_busy", 64'(busy), 64'd1);
        check("b2b_valid_low", 64'(meas_valid), 64'd0);
        wait_result("b2b_b", e);
        handshake("b2b_b");

        // Enable gating: 5 en-low cycles inside ACCUM, alternating 16/48 ones.
        e.sum = 256; e.mn = 16; e.mx = 48; e.oor = 0; e.lat = N_SYNC + 2 + 8 + 5;
        sb.push_back(e);
        start_burst(64'h0000_0000_0000_FFFF, 0, 3, 1'b0);
        dl_in = 64'h0000_FFFF_FFFF_FFFF;
        cnt = 0;
        while (!meas_valid && cnt < 200) begin
            tick();
            cnt++;
            if (en) dl_in = (dl_in == 64'h0000_0000_0000_FFFF) ? 64'h0000_FFFF_FFFF_FFFF
                                                                 : 64'h0000_0000_0000_FFFF;
            if (cnt == 6)  en = 1'b0;
            if (cnt == 11) en = 1'b1;
        end
        e = sb.pop_front();
        check("gate_lat", 64'(cnt), 64'(e.lat));
        check("gate_sum", 64'(meas_sum), 64'(e.sum));
        check("gate_min", 64'(meas_min), 64'(e.mn));
        check("gate_max", 64'(meas_max), 64'(e.mx));
        check("gate_oor", 64'(meas_oor), 64'(e.oor));
        handshake("gate");

        // Asynchronous reset mid-ACCUM clears everything without a clock edge.
        start_burst('1, 0, 4, 1'b0);
        repeat (6) tick();
        check("pre_rst_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_valid", 64'(meas_valid), 64'd0);
        check("arst_sum", 64'(meas_sum), 64'd0);
        check("arst_min", 64'(meas_min), 64'd0);
        check("arst_max", 64'(meas_max), 64'd0);
        check("arst_oor", 64'(meas_oor), 64'd0);
        #5 rst_n = 1'b1;
        rises = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (meas_valid) rises++;
        end
        check("no_partial", 64'(rises), 64'd0);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
